// File: rtl/counter_7seg_mux.sv
`timescale 1ns/1ps
// Up/down modulo counter with prescaler, load and wrap pulse, driving a
// time-multiplexed N-digit 7-segment display in decimal (double-dabble) or hex.
module counter_7seg_mux #(
    parameter int F_CLK_HZ   = 50_000_000,
    parameter int COUNT_HZ   = 1,
    parameter int REFRESH_HZ = 4000,
    parameter int DIGITS     = 4,
    parameter int MAX_COUNT  = 255,
    parameter int HEX_MODE   = 0,
    parameter int ACTIVE_LOW = 1,
    localparam int CW = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up_dn,
    input  logic              load,
    input  logic [CW-1:0]     load_val,
    output logic [CW-1:0]     count,
    output logic              wrap,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              busy
);

    localparam int TICK_DIV = F_CLK_HZ / COUNT_HZ;
    localparam int DWELL    = F_CLK_HZ / (REFRESH_HZ * DIGITS);
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DWW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int DIW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DISP_W   = 4 * DIGITS;

    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);
    localparam logic [DIW-1:0] DIGIT_LAST = DIW'(DIGITS - 1);
    localparam logic [CW-1:0]  MAX_CW     = CW'(MAX_COUNT);

    logic [PW-1:0]     presc_q, presc_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wrap_q, wrap_d;
    logic [DWW-1:0]    dwell_q, dwell_d;
    logic [DIW-1:0]    digit_q, digit_d;
    logic [DISP_W-1:0] disp_q;
    logic              tick;
    logic [3:0]        nibble;
    logic [6:0]        seg_raw;
    logic [DIGITS-1:0] an_raw;

    always_comb begin
        tick    = en && (presc_q == PRESC_LAST);
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            presc_d = '0;
            count_d = (load_val > MAX_CW) ? MAX_CW : load_val;
        end else begin
            if (en) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end
            if (tick) begin
                if (up_dn) begin
                    if (count_q == MAX_CW) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = MAX_CW;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
        end
    end

    // The digit scan free-runs so the display never freezes, even with en low.
    always_comb begin
        dwell_d = dwell_q + 1'b1;
        digit_d = digit_q;
        if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            dwell_q <= '0;
            digit_q <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            dwell_q <= dwell_d;
            digit_q <= digit_d;
        end
    end

    generate
        if (HEX_MODE != 0) begin : g_hex
            logic [DISP_W-1:0] disp_d;

            always_comb begin
                disp_d = DISP_W'(count_q);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    disp_q <= '0;
                end else begin
                    disp_q <= disp_d;
                end
            end

            assign busy = 1'b0;
        end else begin : g_dec
            typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} conv_state_t;

            localparam int BW = $clog2(CW + 1);
            localparam logic [BW-1:0] BIT_LAST = BW'(CW - 1);

            conv_state_t       state_q, state_d;
            logic [CW-1:0]     snap_q, snap_d;
            logic [CW-1:0]     sh_q, sh_d;
            logic [CW-1:0]     last_q, last_d;
            logic [BW-1:0]     bit_q, bit_d;
            logic [DISP_W-1:0] bcd_q, bcd_d;
            logic [DISP_W-1:0] bcd_adj;
            logic [DISP_W-1:0] disp_d;

            // snap_q keeps the value being converted; sh_q is the copy shifted out MSB-first.
            always_comb begin
                state_d = state_q;
                snap_d  = snap_q;
                sh_d    = sh_q;
                last_d  = last_q;
                bit_d   = bit_q;
                bcd_d   = bcd_q;
                disp_d  = disp_q;
                bcd_adj = bcd_q;
                for (int i = 0; i < DIGITS; i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5) begin
                        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                    end
                end
                unique case (state_q)
                    S_IDLE: begin
                        if (count_q != last_q) begin
                            state_d = S_SHIFT;
                            snap_d  = count_q;
                            sh_d    = count_q;
                            bcd_d   = '0;
                            bit_d   = '0;
                        end
                    end
                    S_SHIFT: begin
                        bcd_d = {bcd_adj[DISP_W-2:0], sh_q[CW-1]};
                        sh_d  = sh_q << 1;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                    S_DONE: begin
                        disp_d  = bcd_q;
                        last_d  = snap_q;
                        state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= S_IDLE;
                    snap_q  <= '0;
                    sh_q    <= '0;
                    last_q  <= '0;
                    bit_q   <= '0;
                    bcd_q   <= '0;
                    disp_q  <= '0;
                end else begin
                    state_q <= state_d;
                    snap_q  <= snap_d;
                    sh_q    <= sh_d;
                    last_q  <= last_d;
                    bit_q   <= bit_d;
                    bcd_q   <= bcd_d;
                    disp_q  <= disp_d;
                end
            end

            assign busy = (state_q == S_SHIFT);
        end
    endgenerate

    always_comb begin
        nibble = disp_q[4*digit_q +: 4];
        an_raw = DIGITS'(1) << digit_q;
        unique case (nibble)
            4'h0:    seg_raw = 7'h3F;
            4'h1:    seg_raw = 7'h06;
            4'h2:    seg_raw = 7'h5B;
            4'h3:    seg_raw = 7'h4F;
            4'h4:    seg_raw = 7'h66;
            4'h5:    seg_raw = 7'h6D;
            4'h6:    seg_raw = 7'h7D;
            4'h7:    seg_raw = 7'h07;
            4'h8:    seg_raw = 7'h7F;
            4'h9:    seg_raw = 7'h6F;
            4'hA:    seg_raw = 7'h77;
            4'hB:    seg_raw = 7'h7C;
            4'hC:    seg_raw = 7'h39;
            4'hD:    seg_raw = 7'h5E;
            4'hE:    seg_raw = 7'h79;
            default: seg_raw = 7'h71;
        endcase
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign seg   = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    assign an    = (ACTIVE_LOW != 0) ? ~an_raw : an_raw;

endmodule

// File: tb/tb_counter_7seg_mux.sv
`timescale 1ns/1ps
// Self-checking bench: a cycle model queues the expected outputs when each
// input vector is driven; they are popped and compared after the clock edge.
module tb_counter_7seg_mux;

    localparam int F_CLK    = 1000;
    localparam int CNT_HZ   = 100;
    localparam int REF_HZ   = 50;
    localparam int DIGITS   = 4;
    localparam int MAX      = 255;
    localparam int MAX2     = 199;
    localparam int CW       = 8;
    localparam int TICK_DIV = 10;
    localparam int DWELL    = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              up_dn = 1'b0;
    logic              load = 1'b0;
    logic [CW-1:0]     load_val = '0;
    logic [CW-1:0]     count, count2;
    logic              wrap, wrap2, busy, busy2;
    logic [6:0]        seg, seg2;
    logic [DIGITS-1:0] an, an2;

    typedef struct packed {
        logic [CW-1:0]     count;
        logic              wrap;
        logic              busy;
        logic [DIGITS-1:0] an;
        logic [6:0]        seg;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int failures = 0;

    int m_presc, m_count, m_wrap, m_conv, m_left, m_snap, m_last, m_disp, m_dwell, m_digit;

    always #5 clk = ~clk;

    counter_7seg_mux #(
        .F_CLK_HZ(F_CLK), .COUNT_HZ(CNT_HZ), .REFRESH_HZ(REF_HZ), .DIGITS(DIGITS),
        .MAX_COUNT(MAX), .HEX_MODE(0), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count), .wrap(wrap), .seg(seg), .an(an), .busy(busy)
    );

    // Second instance exercises the load clamp and the hex display path.
    counter_7seg_mux #(
        .F_CLK_HZ(F_CLK), .COUNT_HZ(CNT_HZ), .REFRESH_HZ(REF_HZ), .DIGITS(DIGITS),
        .MAX_COUNT(MAX2), .HEX_MODE(1), .ACTIVE_LOW(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count2), .wrap(wrap2), .seg(seg2), .an(an2), .busy(busy2)
    );

    function automatic logic [6:0] glyph(input int nib);
        logic [6:0] g;
        case (nib)
            0: g = 7'h3F;  1: g = 7'h06;  2: g = 7'h5B;  3: g = 7'h4F;
            4: g = 7'h66;  5: g = 7'h6D;  6: g = 7'h7D;  7: g = 7'h07;
            8: g = 7'h7F;  9: g = 7'h6F; 10: g = 7'h77; 11: g = 7'h7C;
            12: g = 7'h39; 13: g = 7'h5E; 14: g = 7'h79; default: g = 7'h71;
        endcase
        return ~g;
    endfunction

    function automatic int dec_digit(input int value, input int pos);
        int v;
        v = value;
        for (int k = 0; k < pos; k++) v = v / 10;
        return v % 10;
    endfunction

    function automatic logic [DIGITS-1:0] an_for(input int digit);
        logic [DIGITS-1:0] onehot;
        onehot = '0;
        onehot[digit] = 1'b1;
        return ~onehot;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_presc = 0; m_count = 0; m_wrap = 0; m_conv = 0; m_left = 0;
        m_snap = 0; m_last = 0; m_disp = 0; m_dwell = 0; m_digit = 0;
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, then compare.
    task automatic applyStimulus(input logic e, input logic u, input logic l, input logic [CW-1:0] lv);
        exp_t xp;
        bit   tick;
        en = e; up_dn = u; load = l; load_val = lv;
        tick = e && (m_presc == TICK_DIV - 1);
        case (m_conv)
            0: if (m_count != m_last) begin m_conv = 1; m_snap = m_count; m_left = CW; end
            1: if (m_left == 1) m_conv = 2; else m_left--;
            default: begin m_disp = m_snap; m_last = m_snap; m_conv = 0; end
        endcase
        m_wrap = 0;
        if (l) begin
            m_presc = 0;
            m_count = (int'(lv) > MAX) ? MAX : int'(lv);
        end else begin
            if (e) m_presc = tick ? 0 : m_presc + 1;
            if (tick && u) begin
                if (m_count == MAX) begin m_count = 0; m_wrap = 1; end else m_count++;
            end else if (tick) begin
                if (m_count == 0) begin m_count = MAX; m_wrap = 1; end else m_count--;
            end
        end
        if (m_dwell == DWELL - 1) begin
            m_dwell = 0;
            m_digit = (m_digit + 1) % DIGITS;
        end else begin
            m_dwell++;
        end
        xp.count = CW'(m_count);
        xp.wrap  = m_wrap[0];
        xp.busy  = (m_conv == 1);
        xp.an    = an_for(m_digit);
        xp.seg   = glyph(dec_digit(m_disp, m_digit));
        exp_q.push_back(xp);
        @(posedge clk);
        @(negedge clk);
        xp = exp_q.pop_front();
        checkOutput("count", 32'(count), 32'(xp.count));
        checkOutput("wrap", 32'(wrap), 32'(xp.wrap));
        checkOutput("busy", 32'(busy), 32'(xp.busy));
        checkOutput("an", 32'(an), 32'(xp.an));
        checkOutput("seg", 32'(seg), 32'(xp.seg));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        int  wraps_seen;
        int  busy_rises;
        bit  prev_busy;
        bit  hit;

        modelReset();
        @(negedge clk);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_wrap", 32'(wrap), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_an", 32'(an), 32'b1110);
        checkOutput("rst_seg", 32'(seg), 32'b1000000);
        checkOutput("rst_count2", 32'(count2), 32'd0);
        checkOutput("rst_busy2", 32'(busy2), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);

        applyStimulus(1'b1, 1'b1, 1'b1, 8'd254);
        wraps_seen = 0;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, '0);
            wraps_seen += int'(wrap);
        end
        checkOutput("up_wrap_pulses", 32'(wraps_seen), 32'd1);
        idle(15);

        applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
        hit = 0;
        for (int i = 0; i < 12 && !hit; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, '0);
            hit = wrap;
        end
        checkOutput("down_wrap_seen", 32'(hit), 32'd1);
        checkOutput("down_wrap_count", 32'(count), 32'd255);
        idle(15);
        hit = 0;
        for (int i = 0; i < 25 && !hit; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0);
            hit = (an == 4'b1011);
        end
        checkOutput("digit2_reached", 32'(hit), 32'd1);
        checkOutput("digit2_glyph", 32'(seg), 32'b0100100);

        for (int i = 0; i < 10 && m_presc != TICK_DIV - 1; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd100);
        checkOutput("load_beats_tick", 32'(count), 32'd100);

        applyStimulus(1'b0, 1'b1, 1'b1, 8'd250);
        checkOutput("clamp_count2", 32'(count2), 32'd199);
        idle(20);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0);
            checkOutput("hex_an2", 32'(an2), 32'(an_for(m_digit)));
            checkOutput("hex_seg2", 32'(seg2), 32'(glyph((MAX2 >> (4 * m_digit)) & 15)));
        end
        for (int i = 0; i < TICK_DIV; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("clamp_wrap_count2", 32'(count2), 32'd0);
        checkOutput("clamp_wrap2", 32'(wrap2), 32'd1);
        checkOutput("hex_busy2", 32'(busy2), 32'd0);

        busy_rises = 0;
        prev_busy  = 0;
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd123);
        for (int i = 0; i < 42; i++) begin
            if (i == 2) applyStimulus(1'b0, 1'b1, 1'b1, 8'd45);
            else        applyStimulus(1'b0, 1'b1, 1'b0, '0);
            if (busy && !prev_busy) busy_rises++;
            prev_busy = busy;
        end
        checkOutput("busy_pulses", 32'(busy_rises), 32'd2);

        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 37; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 25; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);

        applyStimulus(1'b0, 1'b1, 1'b1, 8'd77);
        idle(3);
        checkOutput("busy_before_abort", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_count", 32'(count), 32'd0);
        checkOutput("abort_wrap", 32'(wrap), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_an", 32'(an), 32'b1110);
        checkOutput("abort_seg", 32'(seg), 32'b1000000);
        checkOutput("abort_count2", 32'(count2), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
